// File: rtl/risc_spm_prog_loader.sv
// risc_spm_prog_loader
//   Streams program words from a valid/ready source into the RISC SPM unified
//   memory, starting at address 0. The processor is held in reset (cpu_rst_o
//   low) for the whole load. It is released RST_HOLD cycles after the final
//   word is accepted.
//
// Ports
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   start_i         one-cycle pulse that begins a load (honoured in IDLE/RUN/ERROR)
//   in_valid_i      source offers in_data_i / in_last_i
//   in_data_i       program word
//   in_last_i       marks the final word of the program
//   in_ready_o      loader accepts a word this cycle (registered, state-only)
//   mem_we_o        registered write strobe, one cycle per accepted word
//   mem_addr_o      registered write address
//   mem_wdata_o     registered write data
//   cpu_rst_o       active-low processor reset
//   load_done_o     high while the processor runs the loaded program
//   err_overflow_o  sticky: memory filled without seeing in_last_i
//   word_count_o    words accepted in the current or last load (0..2^ADDR_W)
module risc_spm_prog_loader #(
  parameter int ADDR_W   = 8,
  parameter int WORD_W   = 8,
  parameter int RST_HOLD = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic              cpu_rst_o,
  output logic              load_done_o,
  output logic              err_overflow_o,
  output logic [ADDR_W:0]   word_count_o
);

  // Hold counter only needs to reach RST_HOLD-1.
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_RUN,
    ST_ERROR
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     word_count_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                in_ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_wdata_q;
  logic                cpu_rst_q;
  logic                load_done_q;
  logic                err_q;
  logic                accept;

  // in_ready_q is set only while in LOAD, so this is the LOAD-state handshake.
  assign accept = in_ready_q & in_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      word_count_q <= '0;
      hold_q       <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rst_q    <= 1'b0;
      load_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Strobe is a single-cycle pulse unless another accept happens.
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (start_i) begin
            state_q      <= ST_LOAD;
            in_ready_q   <= 1'b1;
            ptr_q        <= '0;
            word_count_q <= '0;
            err_q        <= 1'b0;
            cpu_rst_q    <= 1'b0;
            load_done_q  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= ptr_q;
            mem_wdata_q  <= in_data_i;
            ptr_q        <= ptr_q + 1'b1;
            word_count_q <= word_count_q + 1'b1;
            // in_last wins over the full-memory check, so an exact fill completes.
            if (in_last_i) begin
              state_q    <= ST_RELEASE;
              in_ready_q <= 1'b0;
              // The accept edge counts as the first of the RST_HOLD cycles.
              hold_q     <= HOLD_W'(RST_HOLD - 1);
            end else if (ptr_q == PTR_MAX) begin
              state_q    <= ST_ERROR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (hold_q == '0) begin
            state_q     <= ST_RUN;
            cpu_rst_q   <= 1'b1;
            load_done_q <= 1'b1;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign load_done_o    = load_done_q;
  assign err_overflow_o = err_q;
  assign word_count_o   = word_count_q;

endmodule

// File: tb/tb_risc_spm_prog_loader.sv
// tb_risc_spm_prog_loader
//   Self-checking bench for risc_spm_prog_loader with a 16-word memory.
//   Expected addresses, counts and release timing come from a simple model of
//   the load: the k-th accepted word of a load lands at address k, and the
//   processor is released RST_HOLD cycles after the final accept.
module tb_risc_spm_prog_loader;

  localparam int ADDR_W   = 4;
  localparam int WORD_W   = 8;
  localparam int RST_HOLD = 2;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic              in_valid_i;
  logic [WORD_W-1:0] in_data_i;
  logic              in_last_i;
  logic              in_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [WORD_W-1:0] mem_wdata_o;
  logic              cpu_rst_o;
  logic              load_done_o;
  logic              err_overflow_o;
  logic [ADDR_W:0]   word_count_o;

  int total = 0;
  int bad   = 0;
  int we_pulses = 0;
  int exp_ptr   = 0;
  int exp_count = 0;

  risc_spm_prog_loader #(
    .ADDR_W  (ADDR_W),
    .WORD_W  (WORD_W),
    .RST_HOLD(RST_HOLD)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .in_last_i     (in_last_i),
    .in_ready_o    (in_ready_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .cpu_rst_o     (cpu_rst_o),
    .load_done_o   (load_done_o),
    .err_overflow_o(err_overflow_o),
    .word_count_o  (word_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Count write strobes independently of the per-accept checks.
  always @(negedge clk_i) begin
    if (mem_we_o === 1'b1) we_pulses <= we_pulses + 1;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    start_i    = 1'b1;
    step();
    start_i    = 1'b0;
    exp_ptr    = 0;
    exp_count  = 0;
    total++;
    if (in_ready_o !== 1'b1 || cpu_rst_o !== 1'b0 || load_done_o !== 1'b0 ||
        err_overflow_o !== 1'b0 || word_count_o !== '0) begin
      bad++;
      $display("FAIL start_entry: rdy=%b cpu_rst=%b done=%b err=%b cnt=%0d required rdy=1 cpu_rst=0 done=0 err=0 cnt=0",
               in_ready_o, cpu_rst_o, load_done_o, err_overflow_o, word_count_o);
    end
  endtask

  // Offers n words; gaps of gmin..gmax idle cycles precede every word but the first.
  task automatic send_words(input int n, input bit fixed, input bit last_at_end,
                            input int gmin, input int gmax);
    for (int i = 0; i < n; i++) begin
      int gap;
      int waited;
      bit rdy;
      logic [WORD_W-1:0] d;
      logic [ADDR_W-1:0] ea;
      gap = (i == 0) ? 0 : int'($urandom_range(gmax, gmin));
      for (int g = 0; g < gap; g++) begin
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        in_data_i  = 8'($urandom);
        step();
        total++;
        if (mem_we_o !== 1'b0) begin
          bad++;
          $display("FAIL gap_no_write: mem_we=%b required 0", mem_we_o);
        end
      end
      d = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
      in_valid_i = 1'b1;
      in_data_i  = d;
      in_last_i  = last_at_end && (i == n - 1);
      rdy = 1'b0;
      waited = 0;
      while (!rdy && waited < 8) begin
        rdy = (in_ready_o === 1'b1);
        step();
        waited++;
      end
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      total++;
      if (!rdy) begin
        bad++;
        $display("FAIL accept_timeout: word %0d not accepted, in_ready=%b required 1", i, in_ready_o);
        return;
      end
      exp_count++;
      ea = ADDR_W'(exp_ptr);
      total++;
      if (mem_we_o !== 1'b1 || mem_addr_o !== ea || mem_wdata_o !== d ||
          word_count_o !== (ADDR_W+1)'(exp_count)) begin
        bad++;
        $display("FAIL write: we=%b addr=%0d data=%h cnt=%0d required we=1 addr=%0d data=%h cnt=%0d",
                 mem_we_o, mem_addr_o, mem_wdata_o, word_count_o, ea, d, exp_count);
      end
      exp_ptr = (exp_ptr + 1) % DEPTH;
    end
  endtask

  // Called just after the final accept; checks the reset-hold interval.
  task automatic check_release(input bit poke_start);
    total++;
    if (in_ready_o !== 1'b0 || cpu_rst_o !== 1'b0 || load_done_o !== 1'b0) begin
      bad++;
      $display("FAIL release_entry: rdy=%b cpu_rst=%b done=%b required 0 0 0",
               in_ready_o, cpu_rst_o, load_done_o);
    end
    for (int k = 1; k < RST_HOLD; k++) begin
      start_i = poke_start && (k == 1);
      step();
      start_i = 1'b0;
      total++;
      if (cpu_rst_o !== 1'b0 || load_done_o !== 1'b0 || mem_we_o !== 1'b0) begin
        bad++;
        $display("FAIL release_hold: cycle %0d cpu_rst=%b done=%b we=%b required 0 0 0",
                 k, cpu_rst_o, load_done_o, mem_we_o);
      end
    end
    step();
    total++;
    if (cpu_rst_o !== 1'b1 || load_done_o !== 1'b1 || err_overflow_o !== 1'b0 ||
        word_count_o !== (ADDR_W+1)'(exp_count)) begin
      bad++;
      $display("FAIL release_run: cpu_rst=%b done=%b err=%b cnt=%0d required 1 1 0 %0d",
               cpu_rst_o, load_done_o, err_overflow_o, word_count_o, exp_count);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (in_ready_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== '0 || mem_wdata_o !== '0 ||
        cpu_rst_o !== 1'b0 || load_done_o !== 1'b0 || err_overflow_o !== 1'b0 || word_count_o !== '0) begin
      bad++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%0d data=%h cpu_rst=%b done=%b err=%b cnt=%0d required all 0",
               in_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, cpu_rst_o, load_done_o, err_overflow_o, word_count_o);
    end
    rst_ni = 1'b1;
    in_valid_i = 1'b1;
    step();
    step();
    in_valid_i = 1'b0;
    total++;
    if (in_ready_o !== 1'b0 || mem_we_o !== 1'b0 || cpu_rst_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: rdy=%b we=%b cpu_rst=%b required 0 0 0", in_ready_o, mem_we_o, cpu_rst_o);
    end
  endtask

  task automatic test_basic();
    int base;
    base = we_pulses;
    do_start();
    send_words(3, 1'b1, 1'b1, 0, 0);
    check_release(1'b0);
    total++;
    if (we_pulses - base !== 3) begin
      bad++;
      $display("FAIL basic_pulses: got %0d required 3", we_pulses - base);
    end
  endtask

  task automatic test_stalled();
    int base;
    base = we_pulses;
    do_start();
    send_words(3, 1'b1, 1'b1, 2, 2);
    check_release(1'b0);
    total++;
    if (we_pulses - base !== 3) begin
      bad++;
      $display("FAIL stalled_pulses: got %0d required 3", we_pulses - base);
    end
  endtask

  task automatic test_random_loads();
    for (int r = 0; r < 6; r++) begin
      int n;
      int base;
      n = int'($urandom_range(DEPTH, 1));
      base = we_pulses;
      do_start();
      send_words(n, 1'b0, 1'b1, 0, 3);
      check_release(1'b0);
      total++;
      if (we_pulses - base !== n) begin
        bad++;
        $display("FAIL random_pulses: load %0d got %0d required %0d", r, we_pulses - base, n);
      end
    end
  endtask

  task automatic test_overflow();
    int base;
    base = we_pulses;
    do_start();
    send_words(DEPTH, 1'b0, 1'b0, 0, 1);
    total++;
    if (err_overflow_o !== 1'b1 || in_ready_o !== 1'b0 || cpu_rst_o !== 1'b0 ||
        word_count_o !== (ADDR_W+1)'(DEPTH)) begin
      bad++;
      $display("FAIL overflow_entry: err=%b rdy=%b cpu_rst=%b cnt=%0d required 1 0 0 %0d",
               err_overflow_o, in_ready_o, cpu_rst_o, word_count_o, DEPTH);
    end
    in_valid_i = 1'b1;
    in_data_i  = 8'hEE;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (err_overflow_o !== 1'b1 || in_ready_o !== 1'b0 || cpu_rst_o !== 1'b0 || mem_we_o !== 1'b0) begin
        bad++;
        $display("FAIL overflow_hold: err=%b rdy=%b cpu_rst=%b we=%b required 1 0 0 0",
                 err_overflow_o, in_ready_o, cpu_rst_o, mem_we_o);
      end
    end
    in_valid_i = 1'b0;
    total++;
    if (we_pulses - base !== DEPTH) begin
      bad++;
      $display("FAIL overflow_pulses: got %0d required %0d", we_pulses - base, DEPTH);
    end
    do_start();
    send_words(2, 1'b0, 1'b1, 0, 1);
    check_release(1'b0);
  endtask

  task automatic test_exact_fill();
    do_start();
    send_words(DEPTH, 1'b0, 1'b1, 0, 1);
    check_release(1'b0);
  endtask

  task automatic test_reload_ignored_start();
    do_start();
    send_words(3, 1'b0, 1'b0, 0, 0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    total++;
    if (in_ready_o !== 1'b1 || word_count_o !== 5'd3 || mem_we_o !== 1'b0) begin
      bad++;
      $display("FAIL start_in_load: rdy=%b cnt=%0d we=%b required 1 3 0", in_ready_o, word_count_o, mem_we_o);
    end
    send_words(2, 1'b0, 1'b1, 0, 0);
    check_release(1'b1);
    // start from RUN drops cpu_rst on the edge; do_start checks it.
    do_start();
    send_words(2, 1'b0, 1'b1, 0, 0);
    check_release(1'b0);
  endtask

  task automatic test_midload_reset();
    int base;
    do_start();
    send_words(5, 1'b0, 1'b0, 0, 1);
    rst_ni = 1'b0;
    #1;
    total++;
    if (in_ready_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== '0 || mem_wdata_o !== '0 ||
        cpu_rst_o !== 1'b0 || load_done_o !== 1'b0 || err_overflow_o !== 1'b0 || word_count_o !== '0) begin
      bad++;
      $display("FAIL midload_reset: rdy=%b we=%b addr=%0d data=%h cpu_rst=%b done=%b err=%b cnt=%0d required all 0",
               in_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, cpu_rst_o, load_done_o, err_overflow_o, word_count_o);
    end
    step();
    rst_ni = 1'b1;
    base = we_pulses;
    in_valid_i = 1'b1;
    in_data_i  = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (in_ready_o !== 1'b0 || mem_we_o !== 1'b0) begin
        bad++;
        $display("FAIL idle_no_write: rdy=%b we=%b required 0 0", in_ready_o, mem_we_o);
      end
    end
    in_valid_i = 1'b0;
    total++;
    if (we_pulses - base !== 0) begin
      bad++;
      $display("FAIL idle_pulses: got %0d required 0", we_pulses - base);
    end
    do_start();
    send_words(4, 1'b0, 1'b1, 0, 2);
    check_release(1'b0);
  endtask

  task automatic test_reset_in_run();
    total++;
    if (cpu_rst_o !== 1'b1) begin
      bad++;
      $display("FAIL run_before_reset: cpu_rst=%b required 1", cpu_rst_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if (cpu_rst_o !== 1'b0 || load_done_o !== 1'b0 || word_count_o !== '0) begin
      bad++;
      $display("FAIL run_async_reset: cpu_rst=%b done=%b cnt=%0d required 0 0 0",
               cpu_rst_o, load_done_o, word_count_o);
    end
    step();
    rst_ni = 1'b1;
    step();
  endtask

  initial begin
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    in_last_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    test_reset();
    test_basic();
    test_stalled();
    test_random_loads();
    test_overflow();
    test_exact_fill();
    test_reload_ignored_start();
    test_midload_reset();
    test_reset_in_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
